// File: rtl/answer_seq_pkg.sv
// Shared types and constants for the LCB answer-table frame sequencer.
// The optional trailing XOR byte is enabled by defining ANSWER_SEQ_CRC_EN.
package answer_seq_pkg;

    localparam int ADDR_W = 5;
    localparam int BYTE_W = 8;

    localparam logic [ADDR_W-1:0] PARK_ADDR = '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_SEND,
        S_CRC,
        S_GAP
    } state_e;

endpackage

// File: rtl/answer_xor_acc.sv
// Running XOR of the frame bytes; feeds the trailing check byte when
// ANSWER_SEQ_CRC_EN is defined.
module answer_xor_acc
    import answer_seq_pkg::*;
(
    input  logic              clk80MHz,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [BYTE_W-1:0] i_byte,
    output logic [BYTE_W-1:0] o_acc
);

    logic [BYTE_W-1:0] r_acc;

    always_ff @(posedge clk80MHz or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc ^ i_byte;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/answer_sequencer.sv
// Walks the answer table once per poll and streams its bytes to the serializer.
// Define ANSWER_SEQ_CRC_EN to append an XOR check byte carrying tx_last.
module answer_sequencer
    import answer_seq_pkg::*;
#(
    parameter int WORDS      = 20,
    parameter int GAP_CYCLES = 4
) (
    input  logic              clk80MHz,
    input  logic              rst,
    input  logic              req,
    output logic              busy,
    output logic [ADDR_W-1:0] ans_addr,
    input  logic [BYTE_W-1:0] ans_data,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_last,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        drop_cnt
);

    localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(WORDS - 1);
    localparam logic [7:0]        GAP_LAST = 8'(GAP_CYCLES - 1);

    state_e            r_state;
    logic [ADDR_W-1:0] r_k;
    logic [ADDR_W-1:0] r_ans_addr;
    logic [BYTE_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic              r_tx_last;
    logic              r_busy;
    logic [15:0]       r_frame_cnt;
    logic [7:0]        r_drop_cnt;
    logic [7:0]        r_gap_cnt;

    logic              w_last_word;
    logic [ADDR_W-1:0] w_k_next;

    assign w_last_word = (r_k == K_LAST);
    assign w_k_next    = r_k + ADDR_W'(1);

`ifdef ANSWER_SEQ_CRC_EN
    logic              w_start;
    logic              w_fold;
    logic [BYTE_W-1:0] w_crc;

    assign w_start = (r_state == S_IDLE) && req;
    assign w_fold  = (r_state == S_WAIT);

    answer_xor_acc u_xor_acc (
        .clk80MHz (clk80MHz),
        .rst      (rst),
        .i_clear  (w_start),
        .i_en     (w_fold),
        .i_byte   (ans_data),
        .o_acc    (w_crc)
    );
`endif

    // NOTE: sequential state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk80MHz or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= '0;
            r_ans_addr  <= PARK_ADDR;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_last   <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
            r_gap_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_k        <= '0;
                        r_ans_addr <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= S_SETUP;
                    end
                end
                // Address is shown for one clock only, so the table's last word never dwells.
                S_SETUP: begin
                    r_ans_addr <= PARK_ADDR;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_tx_data  <= ans_data;
                    r_tx_valid <= 1'b1;
`ifdef ANSWER_SEQ_CRC_EN
                    r_tx_last  <= 1'b0;
`else
                    r_tx_last  <= w_last_word;
`endif
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        if (!w_last_word) begin
                            r_k        <= w_k_next;
                            r_ans_addr <= w_k_next;
                            r_tx_valid <= 1'b0;
                            r_state    <= S_SETUP;
                        end else begin
`ifdef ANSWER_SEQ_CRC_EN
                            r_tx_data  <= w_crc;
                            r_tx_last  <= 1'b1;
                            r_state    <= S_CRC;
`else
                            r_tx_valid  <= 1'b0;
                            r_tx_last   <= 1'b0;
                            r_frame_cnt <= r_frame_cnt + 16'd1;
                            r_gap_cnt   <= '0;
                            r_state     <= S_GAP;
`endif
                        end
                    end
                end
`ifdef ANSWER_SEQ_CRC_EN
                S_CRC: begin
                    if (tx_ready) begin
                        r_tx_valid  <= 1'b0;
                        r_tx_last   <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                        r_gap_cnt   <= '0;
                        r_state     <= S_GAP;
                    end
                end
`endif
                S_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk80MHz or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (req && (r_state != S_IDLE) && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    assign busy      = r_busy;
    assign ans_addr  = r_ans_addr;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign tx_last   = r_tx_last;
    assign frame_cnt = r_frame_cnt;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_answer_sequencer.sv
// Self-checking bench for answer_sequencer: table model, frame-level reference
// model compared every cycle, plus directed literal checks. Honours ANSWER_SEQ_CRC_EN.
module tb_answer_sequencer;

    localparam int WORDS      = 20;
    localparam int GAP_CYCLES = 4;
`ifdef ANSWER_SEQ_CRC_EN
    localparam int FRAME_BYTES = WORDS + 1;
`else
    localparam int FRAME_BYTES = WORDS;
`endif
    localparam int FRAME_CLKS = 3 * WORDS + (FRAME_BYTES - WORDS);

    logic        clk80MHz = 1'b0;
    logic        rst      = 1'b1;
    logic        req      = 1'b0;
    logic        busy;
    logic [4:0]  ans_addr;
    logic [7:0]  ans_data = 8'd0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        tx_last;
    logic [15:0] frame_cnt;
    logic [7:0]  drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    answer_sequencer #(
        .WORDS      (WORDS),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk80MHz  (clk80MHz),
        .rst       (rst),
        .req       (req),
        .busy      (busy),
        .ans_addr  (ans_addr),
        .ans_data  (ans_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_last   (tx_last),
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #6 clk80MHz = ~clk80MHz;

    // Answer table: registered read, word 0 returns its own frame counter.
    logic [7:0] tbl_cnt = 8'd0;
    always @(posedge clk80MHz) begin
        ans_data <= (ans_addr == 5'd0) ? tbl_cnt : 8'(10 * ans_addr);
        if (ans_addr == 5'(WORDS - 1)) tbl_cnt <= tbl_cnt + 8'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference model
    typedef enum int {P_IDLE, P_FETCH, P_OFFER, P_GAP} phase_e;
    phase_e     m_phase  = P_IDLE;
    int         m_low    = 0;
    int         m_k      = 0;
    int         m_gap    = 0;
    logic [7:0] m_q[$];
    logic [15:0] m_frames = 16'd0;
    logic [7:0] m_drop   = 8'd0;
    logic [7:0] m_tbl    = 8'd0;

    // Observation of the last frame, used by the directed checks
    logic       prev_busy  = 1'b0;
    bit         counting   = 1'b0;
    int         cnt_frame  = 0;
    int         last_len   = 0;
    int         gap_clocks = 0;
    int         last_gap   = 0;
    logic [7:0] seen[$];

    task automatic model_start();
        logic [7:0] b;
`ifdef ANSWER_SEQ_CRC_EN
        logic [7:0] acc;
        acc = 8'd0;
`endif
        m_q.delete();
        for (int k = 0; k < WORDS; k++) begin
            b = (k == 0) ? m_tbl : 8'(10 * k);
            m_q.push_back(b);
`ifdef ANSWER_SEQ_CRC_EN
            acc = acc ^ b;
`endif
        end
`ifdef ANSWER_SEQ_CRC_EN
        m_q.push_back(acc);
`endif
        m_phase = P_FETCH;
        m_low   = 2;
        m_k     = 0;
    endtask

    initial begin
        int exp_addr;
        forever begin
            @(negedge clk80MHz);
            if (rst) begin
                m_phase  = P_IDLE;
                m_frames = 16'd0;
                m_drop   = 8'd0;
                m_q.delete();
                prev_busy = 1'b0;
                counting  = 1'b0;
            end else begin
                exp_addr = (m_phase == P_FETCH && m_low == 2) ? m_k : 0;
                check("busy",      32'(busy),      32'(m_phase != P_IDLE));
                check("tx_valid",  32'(tx_valid),  32'(m_phase == P_OFFER));
                check("ans_addr",  32'(ans_addr),  exp_addr);
                check("frame_cnt", 32'(frame_cnt), 32'(m_frames));
                check("drop_cnt",  32'(drop_cnt),  32'(m_drop));
                if (m_phase == P_OFFER) begin
                    check("tx_data", 32'(tx_data), 32'(m_q[0]));
                    check("tx_last", 32'(tx_last), 32'(m_q.size() == 1));
                end

                if (busy && !prev_busy) begin
                    seen.delete();
                    cnt_frame  = 0;
                    counting   = 1'b1;
                    gap_clocks = 0;
                end
                if (busy && counting) cnt_frame++;
                else if (busy)        gap_clocks++;
                if (tx_valid && tx_ready) begin
                    seen.push_back(tx_data);
                    if (tx_last && counting) begin
                        last_len = cnt_frame;
                        counting = 1'b0;
                    end
                end
                if (!busy && prev_busy) last_gap = gap_clocks;
                prev_busy = busy;

                if (m_phase != P_IDLE && req && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
                case (m_phase)
                    P_IDLE:  if (req) model_start();
                    P_FETCH: if (m_low == 1) m_phase = P_OFFER; else m_low--;
                    P_OFFER: begin
                        if (tx_ready) begin
                            void'(m_q.pop_front());
                            if (m_q.size() == 0) begin
                                m_frames = m_frames + 16'd1;
                                m_tbl    = m_tbl + 8'd1;
                                m_phase  = P_GAP;
                                m_gap    = GAP_CYCLES;
                            end else if (m_k != WORDS - 1) begin
                                m_k++;
                                m_phase = P_FETCH;
                                m_low   = 2;
                            end
                        end
                    end
                    P_GAP:   if (m_gap == 1) m_phase = P_IDLE; else m_gap--;
                    default: m_phase = P_IDLE;
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk80MHz);
        #1;
    endtask

    task automatic pulse_req();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 5000) begin tick(); n++; end
        check(name, 32'(busy), 0);
    endtask

    task automatic wait_addr(input logic [4:0] a, input string name);
        int n = 0;
        while (ans_addr != a && n < 500) begin tick(); n++; end
        check(name, 32'(ans_addr), 32'(a));
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!tx_valid && n < 500) begin tick(); n++; end
        check(name, 32'(tx_valid), 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_ans_addr"},  32'(ans_addr),  0);
        check({tag, "_tx_data"},   32'(tx_data),   0);
        check({tag, "_tx_valid"},  32'(tx_valid),  0);
        check({tag, "_tx_last"},   32'(tx_last),   0);
        check({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
        check({tag, "_drop_cnt"},  32'(drop_cnt),  0);
    endtask

    initial begin
        int n;
        // Reset state
        tick(); tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick(); tick();

        // Single frame, sink always ready
        pulse_req();
        wait_idle("frame1_idle");
        // Back-to-back request on the first IDLE clock
        req = 1'b1;
        tick();
        req = 1'b0;
        check("frame1_len",   last_len, FRAME_CLKS);
        check("frame1_gap",   last_gap, GAP_CYCLES);
        check("frame1_cnt",   32'(frame_cnt), 1);
        check("frame1_bytes", seen.size(), FRAME_BYTES);
        check("frame1_w0",    32'(seen[0]), 0);
        check("frame1_w7",    32'(seen[7]), 70);
        check("frame1_w19",   32'(seen[WORDS-1]), 190);
`ifdef ANSWER_SEQ_CRC_EN
        check("frame1_crc",   32'(seen[WORDS]), 32'h80);
`endif
        check("first_idle_req_not_dropped", 32'(drop_cnt), 0);
        wait_idle("frame2_idle");
        tick();
        check("frame2_w0",  32'(seen[0]), 1);
        check("frame2_cnt", 32'(frame_cnt), 2);

        // Five-clock stall on word 7
        pulse_req();
        wait_addr(5'd7, "stall_setup7");
        tx_ready = 1'b0;
        wait_valid("stall_valid");
        for (int i = 0; i < 5; i++) begin
            check("stall_tx_valid", 32'(tx_valid), 1);
            check("stall_tx_data",  32'(tx_data), 70);
            check("stall_ans_addr", 32'(ans_addr), 0);
            tick();
        end
        tx_ready = 1'b1;
        wait_idle("stall_idle");
        tick();
        check("stall_len", last_len, FRAME_CLKS + 5);

        // Dropped requests during SEND and GAP
        pulse_req();
        wait_valid("drop_valid");
        pulse_req();
        n = 0;
        while (!(tx_valid && tx_last) && n < 500) begin tick(); n++; end
        check("drop_last_seen", 32'(tx_valid && tx_last), 1);
        tick();
        pulse_req();
        wait_idle("drop_idle");
        tick();
        check("drop_two",      32'(drop_cnt), 2);
        check("drop_frames",   32'(frame_cnt), 4);
        check("drop_len",      last_len, FRAME_CLKS);

        // Randomised traffic with backpressure
        for (int i = 0; i < 3000; i++) begin
            req      = ($urandom_range(0, 19) == 0);
            tx_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req      = 1'b0;
        tx_ready = 1'b1;
        wait_idle("random_idle");

        // Saturation of the drop counter
        req = 1'b1;
        repeat (500) tick();
        req = 1'b0;
        wait_idle("sat_idle");
        tick();
        check("drop_saturated", 32'(drop_cnt), 255);

        // Reset in the middle of a frame
        pulse_req();
        wait_addr(5'd10, "abort_setup10");
        rst = 1'b1;
        #1;
        check_all_zero("abort");
        tick(); tick();
        rst = 1'b0;
        tick();
        pulse_req();
        wait_valid("after_abort_valid");
        check("after_abort_cnt0", 32'(frame_cnt), 0);
        wait_idle("after_abort_idle");
        tick();
        check("after_abort_cnt1",  32'(frame_cnt), 1);
        check("after_abort_bytes", seen.size(), FRAME_BYTES);
        check("after_abort_len",   last_len, FRAME_CLKS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/answer_sequencer.md
# answer_sequencer

Frame controller for the LCB answer table. On each poll request it walks the table addresses 0..WORDS-1 and absorbs the table's registered read latency. It streams the returned bytes over a valid/ready byte interface toward the link serializer. It owns the table address bus exclusively, so the table's internal frame counter advances exactly once per transmitted frame.

## Interface
Parameters:
- WORDS, 20: answer words per frame. The table's last address, WORDS-1, is the one that advances its frame counter.
- GAP_CYCLES, 4: idle clocks enforced after each frame before the next request is accepted. Range 1..255.

Ports:
- clk80MHz  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  poll request, sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- ans_addr  out  5  registered answer-table address.
- ans_data  in  8  table read data. It is valid one clock after ans_addr is presented.
- tx_data  out  8  output byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  sink accepts the byte on a clock where tx_valid and tx_ready are both high.
- tx_last  out  1  marks the final byte of the frame. Only meaningful while tx_valid is high.
- frame_cnt  out  16  count of completed frames. Wraps from 65535 to 0.
- drop_cnt  out  8  count of requests ignored because the block was busy. Saturates at 255.

## Operation
- States: IDLE, SETUP, WAIT, SEND, CRC (macro only), GAP.
- IDLE: if req is high, set word index k=0 and go to SETUP.
- SETUP: ans_addr = k for this one clock only. Go to WAIT.
- WAIT: ans_data is valid. At the end of this clock, capture tx_data <= ans_data and go to SEND.
- SEND: tx_valid=1, and tx_data is held stable until the handshake. When the handshake completes:
  - if k < WORDS-1: k++ and go to SETUP;
  - otherwise go to CRC (macro on) or GAP (macro off).
- tx_last=1 in SEND for k=WORDS-1 when the macro is off.
- GAP: count GAP_CYCLES clocks, then go to IDLE.
- ans_addr outside SETUP is parked at 0. The table address must never dwell at WORDS-1 for more than the single SETUP clock.
- req sampled in any state other than IDLE increments drop_cnt, saturating at 255.
- frame_cnt increments on the clock the tx_last handshake completes.
- Reset asynchronously forces: state=IDLE, k=0, ans_addr=0, tx_data=0, tx_valid=0, tx_last=0, busy=0, frame_cnt=0, drop_cnt=0, and the CRC accumulator=0.
- A reset during a frame aborts it. No tx_last is emitted, and the next frame restarts at word 0.

## Timing
- req sampled at clock edge E0: busy and SETUP begin in the cycle after E0. tx_valid first rises two clocks later, after edge E2.
- With tx_ready held high, each word takes 3 clocks (SETUP, WAIT, SEND).
- A frame lasts 3*WORDS clocks with the macro off, or 3*WORDS+1 with it on. GAP_CYCLES clocks follow.
- Backpressure stalls only the SEND state. ans_addr stays at 0 during a stall.
- A req on the last GAP clock is counted as dropped. The earliest accepted req is on the first IDLE clock.

## Configuration
- ANSWER_SEQ_CRC_EN defined:
  - An 8-bit XOR accumulator folds each byte as it is captured in WAIT. It is cleared when leaving IDLE.
  - After the last word handshake the block enters CRC. CRC presents the accumulator value as one extra byte with tx_valid=1 and tx_last=1, held until the handshake, then goes to GAP.
- ANSWER_SEQ_CRC_EN undefined: there is no CRC state and no accumulator. tx_last goes on word WORDS-1.

## Structure
- Package answer_seq_pkg holds:
  - the state enum;
  - PARK_ADDR (0);
  - the address width (5);
  - the byte width (8).
- Sub-module answer_xor_acc (clear, enable, byte in, 8-bit out) is instantiated only under ANSWER_SEQ_CRC_EN.
- The FSM, counters and output registers sit in answer_sequencer.

## Test plan
The bench table model returns 8'(10*k) for k≥1 and its frame counter for k=0. The counter increments on each clock the address equals WORDS-1.
- Single req, tx_ready=1, macro off: bytes are 0,10,20,…,190. tx_last is on 190. The frame takes 60 clocks, then a 4-clock GAP. frame_cnt=1.
- Two frames back to back: the second frame's word 0 equals 1 exactly, which proves address 19 was held for exactly one clock.
- tx_ready low for 5 clocks at word 7: tx_data=70 and tx_valid stay stable, ans_addr=0 throughout the stall, and the frame completes in 65 clocks.
- req pulses during SEND and GAP: drop_cnt +1 each, and the frame is unaffected. After 300 dropped reqs, drop_cnt=255.
- rst asserted at word 10: all outputs read 0 immediately. The next req yields word 0 first and frame_cnt remains 0 until that frame completes.
- Macro on, first frame: 21 bytes, with the final byte 0x80 (XOR of the 20 bytes) and tx_last on it. Total 61 clocks.
